paged_memory_slave: RTL and testbench
=====================================

PAGED_MEMORY_SLAVE -- requirements
Module: paged_memory_slave

Interface
REQ-001 Parameter BUSWIDTH, default 16, width of the multiplexed address/data bus and of each memory word.
REQ-002 Parameter DATAPAYLOADSIZE, default 4, number of data words per burst transfer.
REQ-003 Parameter ADDRWIDTH, default 12, in-page word address width; the memory depth is 2**ADDRWIDTH words.
REQ-004 Parameter MEMPAGE, default 4'h2, the only page this memory responds to.
REQ-005 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 Port resetL  input  1  asynchronous, active-low reset.
REQ-007 Port AddrData  inout  BUSWIDTH  multiplexed bus: {page[3:0], addr[11:0]} in the address cycle, data words in the data cycles.
REQ-008 Port AddrValid  input  1  high for exactly one cycle; marks the address cycle.
REQ-009 Port rw  input  1  sampled in the address cycle; 1 = read, 0 = write.
REQ-010 Port Addr  output  ADDRWIDTH  current burst word address, for bench inspection.

Function
REQ-011 The FSM SHALL have the states IDLE, WRITE and READ.
REQ-012 In IDLE with AddrValid=1 and AddrData[15:12]==MEMPAGE, the block SHALL latch AddrData[11:0] into Addr, clear the beat counter, and go to READ if rw=1 or to WRITE if rw=0.
REQ-013 In IDLE with AddrValid=1 and a page other than MEMPAGE, the block SHALL stay in IDLE, perform no memory access, and never drive the bus for that transaction.
REQ-014 In WRITE, on each of the DATAPAYLOADSIZE cycles following the address cycle, the block SHALL store the sampled AddrData into M[Addr], then increment Addr.
REQ-015 In READ, on each of the DATAPAYLOADSIZE cycles following the address cycle, the block SHALL drive AddrData with M[Addr] combinationally, then increment Addr at the clock edge.
REQ-016 Beat 0 SHALL access the latched base address; a 4-word payload is therefore sent MSB-word first, with the first word at the lowest address.
REQ-017 The address increment SHALL be modulo 2**ADDRWIDTH: it wraps from 0xFFF to 0x000 within the same page and never carries into the page field.
REQ-018 After the last beat, the FSM SHALL return to IDLE, so that a new address cycle is accepted on the very next cycle.
REQ-019 AddrValid SHALL be ignored while in WRITE or READ; no burst is aborted or restarted by it.
REQ-020 The block SHALL drive AddrData only during READ data beats and SHALL hold it at high impedance in all other states.
REQ-021 Memory storage SHALL be a 2**ADDRWIDTH x BUSWIDTH array named M, with a synchronous write and an asynchronous read.
REQ-022 Latency: the write data of beat i is visible in M one clock edge after beat i; the read data of beat i is valid throughout beat cycle i.

Reset
REQ-023 Asserting resetL=0 SHALL immediately force the state to IDLE, clear Addr and the beat counter to 0, and release AddrData to high impedance.
REQ-024 A reset asserted in the middle of a burst SHALL abandon the burst; words already written SHALL remain, and no further words SHALL be written.
REQ-025 Reset SHALL NOT clear the contents of M; after power-up, M is undefined until it is written.

Verification
REQ-026 Write to page 2, base 0xFFE, payload 0x0000_0000_0000_FFFF -> M[FFE]=0000, M[FFF]=0000, M[000]=0000, M[001]=FFFF; Addr wraps to 0x000.
REQ-027 Read from page 2, base 0xFFE, immediately after the write -> the bus carries 0000, 0000, 0000, FFFF in beats 1-4, and the bus is high-Z before and after.
REQ-028 Write to page 0, base 0xF00, data FFFF -> M is unchanged, the state stays IDLE, and the bus is never driven.
REQ-029 Read from page 2, base 0xF00 after the page-0 write -> the returned words equal the prior contents of M[F00..F03], not FFFF.
REQ-030 Assert resetL during beat 2 of a write -> IDLE immediately, Addr=0, beats 0-1 stored, beats 2-3 not stored; the next transaction completes normally.
REQ-031 Back-to-back transactions, with a write burst followed by an address cycle on the next cycle -> the second transaction is accepted with no idle gap.

Source files
------------

// File: rtl/paged_memory_slave.sv
// Single-page burst memory slave on a multiplexed address/data bus.
// Address cycle selects page/base; DATAPAYLOADSIZE data beats follow.
module paged_memory_slave #(
  parameter int          BUSWIDTH        = 16,
  parameter int          DATAPAYLOADSIZE = 4,
  parameter int          ADDRWIDTH       = 12,
  parameter logic [3:0]  MEMPAGE         = 4'h2
) (
  input  logic                 clk,
  input  logic                 resetL,
  inout  logic [BUSWIDTH-1:0]  AddrData,
  input  logic                 AddrValid,
  input  logic                 rw,
  output logic [ADDRWIDTH-1:0] Addr
);

  localparam int CW = (DATAPAYLOADSIZE > 1) ? $clog2(DATAPAYLOADSIZE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DATAPAYLOADSIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e               state_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [CW-1:0]        cnt_q;

  logic [BUSWIDTH-1:0]  M [2**ADDRWIDTH];

  logic                 page_hit;

  assign page_hit = (AddrData[ADDRWIDTH +: 4] == MEMPAGE);

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (AddrValid && page_hit) begin
            addr_q  <= AddrData[ADDRWIDTH-1:0];
            cnt_q   <= '0;
            state_q <= rw ? READ : WRITE;
          end
        end
        WRITE, READ: begin
          // Address wraps within the page; AddrValid is ignored mid-burst.
          addr_q <= addr_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      M[addr_q] <= AddrData;
    end
  end

  assign AddrData = (state_q == READ) ? M[addr_q] : 'z;
  assign Addr     = addr_q;

endmodule

// File: tb/tb_paged_memory_slave.sv
// Bench for paged_memory_slave: directed scenarios plus randomized bursts
// checked against an array-based memory model. Undriven bus reads as all-ones.
module tb_paged_memory_slave;

  logic        clk;
  logic        resetL;
  logic        AddrValid;
  logic        rw;
  logic [11:0] Addr;
  wire  [15:0] bus;
  logic        drv_en;
  logic [15:0] drv_val;

  assign bus = drv_en ? drv_val : 'z;
  pullup pu_bus (bus);

  paged_memory_slave #(
    .BUSWIDTH       (16),
    .DATAPAYLOADSIZE(4),
    .ADDRWIDTH      (12),
    .MEMPAGE        (4'h2)
  ) dut (
    .clk      (clk),
    .resetL   (resetL),
    .AddrData (bus),
    .AddrValid(AddrValid),
    .rw       (rw),
    .Addr     (Addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] ref_m [4096];
  bit          known [4096];
  logic [11:0] ref_addr;
  logic [15:0] wdata [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One address cycle plus four beats; abort_beat >= 0 pulls reset in that beat.
  task automatic xfer(input logic [3:0] page, input logic [11:0] base,
                      input bit rd, input int abort_beat);
    bit hit;
    hit       = (page == 4'h2);
    AddrValid = 1'b1;
    rw        = rd;
    drv_en    = 1'b1;
    drv_val   = {page, base};
    @(negedge clk);
    check("addr_cycle_addr", Addr, ref_addr);
    @(posedge clk); #1;
    if (hit) ref_addr = base;
    for (int i = 0; i < 4; i++) begin
      AddrValid = hit ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rd) drv_en = 1'b0;
      else begin drv_en = 1'b1; drv_val = wdata[i]; end
      if (i == abort_beat) begin
        drv_en    = 1'b0;
        AddrValid = 1'b0;
        #2 resetL = 1'b0;
        #1;
        check("rst_addr_now", Addr, 12'h000);
        check("rst_bus_z_now", bus, 16'hFFFF);
        ref_addr = '0;
        @(negedge clk);
        check("rst_addr", Addr, 12'h000);
        @(posedge clk); #1;
        resetL = 1'b1;
        return;
      end
      @(negedge clk);
      check(hit ? "beat_addr" : "miss_addr", Addr, ref_addr);
      if (rd) begin
        if (!hit) check("miss_bus_z", bus, 16'hFFFF);
        else if (known[ref_addr]) check("rdata", bus, ref_m[ref_addr]);
      end
      if (hit && !rd) begin
        ref_m[ref_addr] = wdata[i];
        known[ref_addr] = 1'b1;
      end
      if (hit) ref_addr = ref_addr + 12'd1;
      @(posedge clk); #1;
    end
    AddrValid = 1'b0;
    drv_en    = 1'b0;
  endtask

  task automatic idle_cycle();
    AddrValid = 1'b0;
    drv_en    = 1'b0;
    @(negedge clk);
    check("idle_bus_z", bus, 16'hFFFF);
    check("idle_addr", Addr, ref_addr);
    @(posedge clk); #1;
  endtask

  task automatic set_w(input logic [15:0] a, b, c, d);
    wdata[0] = a; wdata[1] = b; wdata[2] = c; wdata[3] = d;
  endtask

  initial begin
    logic [3:0]  pg;
    logic [11:0] bs;
    resetL    = 1'b0;
    AddrValid = 1'b0;
    rw        = 1'b0;
    drv_en    = 1'b0;
    drv_val   = '0;
    ref_addr  = '0;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;
    #3;
    check("reset_addr", Addr, 12'h000);
    check("reset_bus_z", bus, 16'hFFFF);
    @(posedge clk); @(posedge clk); #1;
    resetL = 1'b1;
    idle_cycle();

    // Seed known contents for later miss and abort checks.
    set_w(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    xfer(4'h2, 12'hF00, 1'b0, -1);
    set_w(16'h5555, 16'h5555, 16'h5555, 16'h5555);
    xfer(4'h2, 12'h020, 1'b0, -1);

    // Wrapping write then immediate read, no idle gap between them.
    set_w(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    xfer(4'h2, 12'hFFE, 1'b0, -1);
    xfer(4'h2, 12'hFFE, 1'b1, -1);
    idle_cycle();

    // Foreign-page write and read are ignored.
    set_w(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    xfer(4'h0, 12'hF00, 1'b0, -1);
    xfer(4'h0, 12'hF00, 1'b1, -1);
    xfer(4'h2, 12'hF00, 1'b1, -1);
    check("miss_kept_F00", {4'h0, ref_m[12'hF00]}, 32'h0000_1111);
    idle_cycle();

    // Reset in beat 2 of a write: beats 0-1 land, 2-3 do not.
    set_w(16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);
    xfer(4'h2, 12'h020, 1'b0, 2);
    idle_cycle();
    xfer(4'h2, 12'h020, 1'b1, -1);
    check("abort_model_022", {16'h0, ref_m[12'h022]}, 32'h0000_5555);
    idle_cycle();

    for (int t = 0; t < 40; t++) begin
      pg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h2;
      if ($urandom_range(0, 3) == 0 && pg == 4'h2) pg = 4'h7;
      bs = ($urandom_range(0, 1) ? 12'hFF0 : 12'h000) | 12'($urandom_range(0, 15));
      set_w(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      xfer(pg, bs, 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
